// File: rtl/reg_read_port_16b.sv
// Read side of the 16-bit register bank: 8 x 16-bit array, two-operand reads with
// write-back bypass, and a pending-write scoreboard that stalls reads of in-flight results.
module reg_read_port_16b #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [NREGS-1:0]  busy_mask
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  set_mask;
   logic [NREGS-1:0]  clr_mask;
   logic [NREGS-1:0]  busy_next;
   logic              haz_a;
   logic              haz_b;
   logic              accept;
   logic [DATA_W-1:0] byp_a;
   logic [DATA_W-1:0] byp_b;

   // Handshake: a request is taken on any rising edge where rd_req && rd_ready;
   // rd_ready never looks at rd_req, and rd_valid pulses for exactly one cycle
   // after each taken request with its operands on rd_data_a/b.
   always_comb begin
      haz_a    = busy_mask[rd_addr_a] && !(wb_we && (wb_addr == rd_addr_a));
      haz_b    = busy_mask[rd_addr_b] && !(wb_we && (wb_addr == rd_addr_b));
      rd_ready = !rst && !haz_a && !haz_b;
      accept   = rd_req && rd_ready;
   end

   // Same-cycle write-back is forwarded so the read sees the post-edge value.
   always_comb begin
      byp_a = regs[rd_addr_a];
      byp_b = regs[rd_addr_b];
      if (wb_we && (wb_addr != '0) && (wb_addr == rd_addr_a)) byp_a = wb_data;
      if (wb_we && (wb_addr != '0) && (wb_addr == rd_addr_b)) byp_b = wb_data;
      if (rd_addr_a == '0) byp_a = '0;
      if (rd_addr_b == '0) byp_b = '0;
   end

   // Set is applied after clear so a new producer wins over a retiring one.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (iss_valid) set_mask[iss_addr] = 1'b1;
      if (wb_we)     clr_mask[wb_addr]  = 1'b1;
      busy_next    = (busy_mask & ~clr_mask) | set_mask;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy_mask <= '0;
         rd_valid  <= 1'b0;
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         if (wb_we && (wb_addr != '0)) regs[wb_addr] <= wb_data;
         busy_mask <= busy_next;
         rd_valid  <= accept;
         if (accept) begin
            rd_data_a <= byp_a;
            rd_data_b <= byp_b;
         end
      end
   end

endmodule

// File: tb/tb_reg_read_port_16b.sv
// Directed table-driven bench for reg_read_port_16b with a short hand-written
// sequence for a stall that resolves after a later write-back.
module tb_reg_read_port_16b;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        iss_valid;
   logic [2:0]  iss_addr;
   logic        rd_req;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic        rd_ready;
   logic        rd_valid;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic [7:0]  busy_mask;

   int n_vec = 0;
   int n_err = 0;

   reg_read_port_16b dut (
      .clk(clk), .rst(rst), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_req(rd_req),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .busy_mask(busy_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wb_we;
      logic [2:0]  wb_addr;
      logic [15:0] wb_data;
      logic        iss_valid;
      logic [2:0]  iss_addr;
      logic        rd_req;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        e_ready;
      logic        e_valid;
      logic [15:0] e_da;
      logic [15:0] e_db;
      logic [7:0]  e_busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic iv, input logic [2:0] ia, input logic rq,
                      input logic [2:0] ra, input logic [2:0] rb,
                      input logic e_rdy, input logic e_v, input logic [15:0] e_da,
                      input logic [15:0] e_db, input logic [7:0] e_busy);
      vec_t v;
      v.rst = r; v.wb_we = we; v.wb_addr = wa; v.wb_data = wd;
      v.iss_valid = iv; v.iss_addr = ia; v.rd_req = rq; v.ra = ra; v.rb = rb;
      v.e_ready = e_rdy; v.e_valid = e_v; v.e_da = e_da; v.e_db = e_db; v.e_busy = e_busy;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic iv, input logic [2:0] ia, input logic rq,
                        input logic [2:0] ra, input logic [2:0] rb);
      rst = r; wb_we = we; wb_addr = wa; wb_data = wd;
      iss_valid = iv; iss_addr = ia; rd_req = rq; rd_addr_a = ra; rd_addr_b = rb;
   endtask

   initial begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);

      //   rst we wa  wdata     iv ia   rq ra   rb    rdy v  da        db        busy
      add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0,     0, 0, 16'h0000, 16'h0000, 8'h00);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 3, 5,     1, 1, 16'h0000, 16'h0000, 8'h00);
      add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0,     1, 0, 16'h0000, 16'h0000, 8'h00);
      add(0, 1, 2, 16'hBEEF, 0, 0, 0, 0, 0,     1, 0, 16'h0000, 16'h0000, 8'h00);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 2, 0,     1, 1, 16'hBEEF, 16'h0000, 8'h00);
      add(0, 1, 0, 16'h1234, 1, 0, 1, 0, 2,     1, 1, 16'h0000, 16'hBEEF, 8'h00);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 0, 0,     1, 1, 16'h0000, 16'h0000, 8'h00);
      add(0, 1, 3, 16'h1111, 0, 0, 1, 3, 3,     1, 1, 16'h1111, 16'h1111, 8'h00);
      add(0, 0, 0, 16'h0000, 1, 4, 1, 4, 1,     1, 1, 16'h0000, 16'h0000, 8'h10);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 4, 1,     0, 0, 16'h0000, 16'h0000, 8'h10);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 4, 1,     0, 0, 16'h0000, 16'h0000, 8'h10);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 4, 1,     0, 0, 16'h0000, 16'h0000, 8'h10);
      add(0, 1, 4, 16'h00A5, 0, 0, 1, 4, 1,     1, 1, 16'h00A5, 16'h0000, 8'h00);
      add(0, 1, 6, 16'h6666, 1, 6, 1, 3, 2,     1, 1, 16'h1111, 16'hBEEF, 8'h40);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 1, 6,     0, 0, 16'h1111, 16'hBEEF, 8'h40);
      add(0, 1, 5, 16'h5555, 0, 0, 1, 6, 6,     0, 0, 16'h1111, 16'hBEEF, 8'h40);
      add(0, 1, 6, 16'h7777, 0, 0, 1, 6, 5,     1, 1, 16'h7777, 16'h5555, 8'h00);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 2, 3,     1, 1, 16'hBEEF, 16'h1111, 8'h00);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 4, 5,     1, 1, 16'h00A5, 16'h5555, 8'h00);
      add(0, 0, 0, 16'h0000, 1, 7, 1, 6, 7,     1, 1, 16'h7777, 16'h0000, 8'h80);
      add(0, 0, 0, 16'h0000, 1, 1, 1, 2, 2,     1, 1, 16'hBEEF, 16'hBEEF, 8'h82);
      add(1, 0, 0, 16'h0000, 0, 0, 1, 2, 2,     0, 0, 16'h0000, 16'h0000, 8'h00);
      add(0, 0, 0, 16'h0000, 0, 0, 1, 2, 6,     1, 1, 16'h0000, 16'h0000, 8'h00);
      add(0, 0, 0, 16'h0000, 1, 5, 0, 0, 0,     1, 0, 16'h0000, 16'h0000, 8'h20);
      add(0, 0, 0, 16'h0000, 1, 5, 1, 5, 0,     0, 0, 16'h0000, 16'h0000, 8'h20);
      add(0, 1, 5, 16'h0ABC, 0, 0, 1, 5, 0,     1, 1, 16'h0ABC, 16'h0000, 8'h00);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].wb_we, tbl[i].wb_addr, tbl[i].wb_data, tbl[i].iss_valid,
               tbl[i].iss_addr, tbl[i].rd_req, tbl[i].ra, tbl[i].rb);
         #1;
         n_vec++;
         check("rd_ready", i, {15'd0, rd_ready}, {15'd0, tbl[i].e_ready});
         @(posedge clk);
         #1;
         check("rd_valid", i, {15'd0, rd_valid}, {15'd0, tbl[i].e_valid});
         check("rd_data_a", i, rd_data_a, tbl[i].e_da);
         check("rd_data_b", i, rd_data_b, tbl[i].e_db);
         check("busy_mask", i, {8'd0, busy_mask}, {8'd0, tbl[i].e_busy});
      end

      // Hand sequence: issue R3, keep requesting it, write back two cycles later,
      // then wait (bounded) for exactly one rd_valid pulse carrying the new value.
      begin
         int seen = 0;
         int first = -1;
         @(negedge clk);
         drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd3, 3'd0);
         @(negedge clk);
         drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd3, 3'd0);
         for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
               wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'hC3C3;
            end
            @(posedge clk);
            #1;
            if (rd_valid) begin
               seen++;
               if (first < 0) first = c;
               n_vec++;
               check("stall_data", c, rd_data_a, 16'hC3C3);
            end
            @(negedge clk);
            wb_we = 1'b0;
            rd_req = 1'b0;
            if (c < 2) rd_req = 1'b1;
            if (c == 2) rd_req = 1'b0;
         end
         n_vec++;
         check("stall_pulses", 0, seen[15:0], 16'd1);
         check("stall_latency", 0, first[15:0], 16'd2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
